// File: rtl/query_stream_dispatcher.sv
// Parses the 128-bit query stream into headers and sequence blocks and hands
// each whole query to one of NUM_ENGINES engines in strict round-robin order.
`timescale 1ns/1ps
module query_stream_dispatcher #(
  parameter int unsigned NUM_PES     = 64,
  parameter int unsigned NUM_ENGINES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [127:0]           in_data,
  output logic                   in_rdy,
  output logic [27:0]            ref_length_out,
  output logic [27:0]            ref_addr_out,
  output logic [15:0]            num_query_blocks_out,
  output logic [15:0]            query_id_out,
  output logic [31:0]            cell_score_threshold_out,
  output logic [NUM_ENGINES-1:0] query_info_valid_out,
  input  logic [NUM_ENGINES-1:0] query_info_rdy_in,
  output logic [NUM_PES*2-1:0]   query_seq_block_out,
  output logic [NUM_ENGINES-1:0] query_seq_block_valid_out,
  input  logic [NUM_ENGINES-1:0] query_seq_block_rdy_in,
  output logic [3:0]             engine_sel_out,
  output logic [31:0]            queries_dispatched_out,
  output logic                   busy_out
);

  localparam logic [3:0] LAST_ENGINE = 4'(NUM_ENGINES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_INFO   = 3'b010,
    S_BLOCKS = 3'b100
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]  r_ptr;
  logic [3:0]  w_ptr_nxt;
  logic [3:0]  w_ptr_adv;
  logic [15:0] r_blk_remaining;
  logic [15:0] w_blk_nxt;
  logic [31:0] r_dispatched;
  logic [31:0] w_dispatched_nxt;
  logic        w_hdr_load;

  logic [27:0] r_ref_length;
  logic [27:0] r_ref_addr;
  logic [15:0] r_num_blocks;
  logic [15:0] r_query_id;
  logic [31:0] r_threshold;

  logic [NUM_ENGINES-1:0] w_sel_onehot;
  logic                   w_sel_info_rdy;
  logic                   w_sel_blk_rdy;
  logic                   w_unused;

  always_comb begin
    w_sel_onehot = '0;
    for (int unsigned e = 0; e < NUM_ENGINES; e++) begin
      w_sel_onehot[e] = (r_ptr == 4'(e));
    end
  end

  // Handshakes of engines other than the selected one are masked out here.
  assign w_sel_info_rdy = |(w_sel_onehot & query_info_rdy_in);
  assign w_sel_blk_rdy  = |(w_sel_onehot & query_seq_block_rdy_in);
  assign w_ptr_adv      = (r_ptr == LAST_ENGINE) ? 4'd0 : r_ptr + 4'd1;

  always_comb begin
    w_state_nxt               = r_state;
    w_ptr_nxt                 = r_ptr;
    w_blk_nxt                 = r_blk_remaining;
    w_dispatched_nxt          = r_dispatched;
    w_hdr_load                = 1'b0;
    in_rdy                    = 1'b0;
    query_info_valid_out      = '0;
    query_seq_block_valid_out = '0;
    case (r_state)
      S_IDLE: begin
        in_rdy = 1'b1;
        if (in_valid) begin
          w_hdr_load  = 1'b1;
          w_blk_nxt   = in_data[79:64];
          w_state_nxt = S_INFO;
        end
      end
      S_INFO: begin
        query_info_valid_out = w_sel_onehot;
        if (w_sel_info_rdy) begin
          w_dispatched_nxt = r_dispatched + 32'd1;
          if (r_blk_remaining == 16'd0) begin
            w_ptr_nxt   = w_ptr_adv;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_BLOCKS;
          end
        end
      end
      S_BLOCKS: begin
        query_seq_block_valid_out = w_sel_onehot & {NUM_ENGINES{in_valid}};
        in_rdy                    = w_sel_blk_rdy;
        if (in_valid && w_sel_blk_rdy) begin
          w_blk_nxt = r_blk_remaining - 16'd1;
          if (r_blk_remaining == 16'd1) begin
            w_ptr_nxt   = w_ptr_adv;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_ptr           <= '0;
      r_blk_remaining <= '0;
      r_dispatched    <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_ptr           <= w_ptr_nxt;
      r_blk_remaining <= w_blk_nxt;
      r_dispatched    <= w_dispatched_nxt;
    end
  end

  // Header fields stay stable until the next header so engines can sample late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref_length <= '0;
      r_ref_addr   <= '0;
      r_num_blocks <= '0;
      r_query_id   <= '0;
      r_threshold  <= '0;
    end else if (w_hdr_load) begin
      r_ref_length <= in_data[27:0];
      r_ref_addr   <= in_data[59:32];
      r_num_blocks <= in_data[79:64];
      r_query_id   <= in_data[95:80];
      r_threshold  <= in_data[127:96];
    end
  end

  assign ref_length_out           = r_ref_length;
  assign ref_addr_out             = r_ref_addr;
  assign num_query_blocks_out     = r_num_blocks;
  assign query_id_out             = r_query_id;
  assign cell_score_threshold_out = r_threshold;
  assign query_seq_block_out      = in_data[NUM_PES*2-1:0];
  assign engine_sel_out           = r_ptr;
  assign queries_dispatched_out   = r_dispatched;
  assign busy_out                 = (r_state != S_IDLE);

  // Header reserved nibbles and, for narrow engines, high block bits are dropped.
  assign w_unused = ^in_data;

endmodule

// File: tb/tb_query_stream_dispatcher.sv
// Directed bench for query_stream_dispatcher: a cycle-vector table plus
// hand-driven sequences for stalls, long queries and mid-query reset.
`timescale 1ns/1ps
module tb_query_stream_dispatcher;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_rdy;
  logic [27:0]  ref_length_out;
  logic [27:0]  ref_addr_out;
  logic [15:0]  num_query_blocks_out;
  logic [15:0]  query_id_out;
  logic [31:0]  cell_score_threshold_out;
  logic [3:0]   query_info_valid_out;
  logic [3:0]   info_rdy;
  logic [127:0] query_seq_block_out;
  logic [3:0]   query_seq_block_valid_out;
  logic [3:0]   blk_rdy;
  logic [3:0]   engine_sel_out;
  logic [31:0]  queries_dispatched_out;
  logic         busy_out;

  query_stream_dispatcher #(.NUM_PES(64), .NUM_ENGINES(4)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .in_valid                 (in_valid),
    .in_data                  (in_data),
    .in_rdy                   (in_rdy),
    .ref_length_out           (ref_length_out),
    .ref_addr_out             (ref_addr_out),
    .num_query_blocks_out     (num_query_blocks_out),
    .query_id_out             (query_id_out),
    .cell_score_threshold_out (cell_score_threshold_out),
    .query_info_valid_out     (query_info_valid_out),
    .query_info_rdy_in        (info_rdy),
    .query_seq_block_out      (query_seq_block_out),
    .query_seq_block_valid_out(query_seq_block_valid_out),
    .query_seq_block_rdy_in   (blk_rdy),
    .engine_sel_out           (engine_sel_out),
    .queries_dispatched_out   (queries_dispatched_out),
    .busy_out                 (busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         vld;
    logic [127:0] data;
    logic [3:0]   irdy;
    logic [3:0]   brdy;
    logic         e_rdy;
    logic [3:0]   e_iv;
    logic [3:0]   e_bv;
    logic [3:0]   e_sel;
    logic         e_busy;
    logic [31:0]  e_cnt;
    logic         chk_hdr;
    logic [127:0] e_hdr;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   exp_ptr  = 0;
  int   exp_cnt  = 0;

  localparam logic [127:0] RSV = 128'h0000_0000_0000_0000_F000_0000_F000_0000;
  localparam logic [127:0] H2  = 128'hDEADBEEF_0007_0003_0123_4567_0000_0089;

  function automatic logic [127:0] mk_hdr(input logic [31:0] thr, input logic [15:0] qid,
                                          input logic [15:0] nb, input logic [27:0] addr,
                                          input logic [27:0] len);
    return {thr, qid, nb, 4'h0, addr, 4'h0, len};
  endfunction

  function automatic vec_t v(input logic r, input logic vld, input logic [127:0] d,
                             input logic [3:0] ir, input logic [3:0] br, input logic erdy,
                             input logic [3:0] eiv, input logic [3:0] ebv, input logic [3:0] esel,
                             input logic ebusy, input logic [31:0] ecnt, input logic ch,
                             input logic [127:0] eh);
    vec_t t;
    t.rst = r; t.vld = vld; t.data = d; t.irdy = ir; t.brdy = br;
    t.e_rdy = erdy; t.e_iv = eiv; t.e_bv = ebv; t.e_sel = esel; t.e_busy = ebusy;
    t.e_cnt = ecnt; t.chk_hdr = ch; t.e_hdr = eh;
    return t;
  endfunction

  function automatic logic [127:0] hdr_now();
    return {cell_score_threshold_out, query_id_out, num_query_blocks_out, 4'h0,
            ref_addr_out, 4'h0, ref_length_out};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_query(input logic [15:0] n, input int unsigned hold,
                             input int unsigned budget);
    logic [3:0]  oh;
    logic        bad_info;
    logic        bad_blk;
    int unsigned xfers;
    int unsigned cyc;
    oh = 4'b0001 << exp_ptr;
    bad_info = 1'b0; bad_blk = 1'b0; xfers = 0; cyc = 0;
    info_rdy = '0; blk_rdy = '0;
    in_valid = 1'b1;
    in_data  = mk_hdr(32'h1000 + 32'(n), 16'(exp_cnt), n, 28'h0ABCDEF, 28'(n));
    @(negedge clk); chk("q_idle_rdy", 128'(in_rdy), 128'(1));
    @(posedge clk); #1;
    in_data  = '1;
    info_rdy = ~oh;
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      if (in_rdy !== 1'b0 || query_info_valid_out !== oh) bad_info = 1'b1;
      @(posedge clk); #1;
    end
    info_rdy = oh;
    @(negedge clk);
    chk("q_info_valid", 128'(query_info_valid_out), 128'(oh));
    chk("q_info_stall", 128'(bad_info), 128'(0));
    @(posedge clk); #1;
    info_rdy = '0;
    exp_cnt++;
    while (xfers < 32'(n) && cyc < budget) begin
      in_valid = ($urandom_range(31) != 0);
      blk_rdy  = 4'($urandom_range(15));
      blk_rdy[exp_ptr] = ($urandom_range(31) != 0);
      in_data  = 128'(xfers);
      @(negedge clk);
      if (busy_out !== 1'b1 || in_rdy !== blk_rdy[exp_ptr] ||
          query_seq_block_valid_out !== (in_valid ? oh : 4'b0000)) bad_blk = 1'b1;
      if (in_valid && blk_rdy[exp_ptr]) xfers++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("q_budget", 128'(cyc >= budget), 128'(0));
    chk("q_block_phase", 128'(bad_blk), 128'(0));
    in_valid = 1'b0; blk_rdy = '0;
    exp_ptr = (exp_ptr == 3) ? 0 : exp_ptr + 1;
    @(negedge clk);
    chk("q_end_busy", 128'(busy_out), 128'(0));
    chk("q_end_sel", 128'(engine_sel_out), 128'(exp_ptr));
    chk("q_end_cnt", 128'(queries_dispatched_out), 128'(exp_cnt));
    @(posedge clk); #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] hq;
    logic [127:0] z0;
    logic [127:0] h1;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; info_rdy = '0; blk_rdy = '0;

    // reset
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 1, 128'h1, 4'hF, 4'hF, 1, 0, 0, 0, 0, 0, 1, 0));
    // four N=2 queries, round robin 0..3
    for (int e = 0; e < 4; e++) begin
      hq = mk_hdr(32'hA0 + 32'(e), 16'(e), 16'd2, 28'h100 + 28'(e), 28'h200 + 28'(e));
      tbl.push_back(v(0, 1, hq | RSV, 0, 0, 1, 0, 0, 4'(e), 0, 32'(e), 0, 0));
      tbl.push_back(v(0, 1, 128'hB0 + 128'(e), 4'hF, 0, 0, 4'b0001 << e, 0, 4'(e), 1,
                      32'(e), 1, hq));
      tbl.push_back(v(0, 1, 128'hC0 + 128'(e), 0, 4'hF, 1, 0, 4'b0001 << e, 4'(e), 1,
                      32'(e + 1), 0, 0));
      tbl.push_back(v(0, 1, 128'hD0 + 128'(e), 0, 4'hF, 1, 0, 4'b0001 << e, 4'(e), 1,
                      32'(e + 1), 0, 0));
    end
    // field-split header, 3 blocks to engine 0, stalls and masked foreign ready
    tbl.push_back(v(0, 1, H2, 0, 0, 1, 0, 0, 0, 0, 4, 0, 0));
    tbl.push_back(v(0, 1, 128'h5555, 4'b1110, 0, 0, 4'b0001, 0, 0, 1, 4, 1,
                    mk_hdr(32'hDEADBEEF, 16'd7, 16'd3, 28'h1234567, 28'h0000089)));
    tbl.push_back(v(0, 0, 128'h5555, 4'b0001, 0, 0, 4'b0001, 0, 0, 1, 4, 0, 0));
    tbl.push_back(v(0, 1, 128'hF1, 0, 4'b0001, 1, 0, 4'b0001, 0, 1, 5, 0, 0));
    tbl.push_back(v(0, 0, 128'hF2, 0, 4'b0001, 1, 0, 0, 0, 1, 5, 0, 0));
    tbl.push_back(v(0, 1, 128'hF2, 0, 4'b1110, 0, 0, 4'b0001, 0, 1, 5, 0, 0));
    tbl.push_back(v(0, 1, 128'hF2, 0, 4'b1111, 1, 0, 4'b0001, 0, 1, 5, 0, 0));
    tbl.push_back(v(0, 1, 128'hF3, 0, 4'b0001, 1, 0, 4'b0001, 0, 1, 5, 0, 0));
    tbl.push_back(v(0, 0, 0, 4'hF, 4'hF, 1, 0, 0, 1, 0, 5, 1, H2));
    // zero-block query then N=1 query from a fresh reset
    z0 = mk_hdr(32'h77, 16'h1, 16'd0, 28'h3, 28'h4);
    h1 = mk_hdr(32'h88, 16'h2, 16'd1, 28'h5, 28'h6);
    tbl.push_back(v(1, 0, 0, 4'hF, 4'hF, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, z0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, h1, 4'b0001, 4'b0001, 0, 4'b0001, 0, 0, 1, 0, 1, z0));
    tbl.push_back(v(0, 1, h1, 0, 0, 1, 0, 0, 1, 0, 1, 1, z0));
    tbl.push_back(v(0, 1, 128'hE1, 4'b0010, 0, 0, 4'b0010, 0, 1, 1, 1, 1, h1));
    tbl.push_back(v(0, 1, 128'hE1, 0, 4'b0010, 1, 0, 4'b0010, 1, 1, 2, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 2, 1, h1));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; in_valid = tbl[i].vld; in_data = tbl[i].data;
      info_rdy = tbl[i].irdy; blk_rdy = tbl[i].brdy;
      @(negedge clk);
      chk($sformatf("v%0d in_rdy", i), 128'(in_rdy), 128'(tbl[i].e_rdy));
      chk($sformatf("v%0d info_valid", i), 128'(query_info_valid_out), 128'(tbl[i].e_iv));
      chk($sformatf("v%0d blk_valid", i), 128'(query_seq_block_valid_out), 128'(tbl[i].e_bv));
      chk($sformatf("v%0d engine_sel", i), 128'(engine_sel_out), 128'(tbl[i].e_sel));
      chk($sformatf("v%0d busy", i), 128'(busy_out), 128'(tbl[i].e_busy));
      chk($sformatf("v%0d dispatched", i), 128'(queries_dispatched_out), 128'(tbl[i].e_cnt));
      chk($sformatf("v%0d blk_data", i), query_seq_block_out, tbl[i].data);
      if (tbl[i].chk_hdr) chk($sformatf("v%0d header", i), hdr_now(), tbl[i].e_hdr);
      @(posedge clk); #1;
    end

    // engine 2 withholds info ready for 10 cycles; no skip to engine 3
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    exp_ptr = 0; exp_cnt = 0;
    drive_query(16'd0, 0, 1000);
    drive_query(16'd0, 0, 1000);
    drive_query(16'd2, 10, 1000);
    drive_query(16'd1, 0, 1000);

    // maximum-length query with random gaps
    drive_query(16'hFFFF, 0, 85000);

    // reset during the second block of an N=5 query
    in_valid = 1'b1; in_data = mk_hdr(32'h5, 16'h5, 16'd5, 28'h1, 28'h2);
    @(posedge clk); #1;
    in_data = 128'h1111; info_rdy = 4'hF;
    @(posedge clk); #1;
    info_rdy = '0; blk_rdy = 4'hF; in_data = 128'h2222;
    @(posedge clk); #1;
    in_data = 128'h3333;
    chk("c_pre_busy", 128'(busy_out), 128'(1));
    chk("c_pre_blk_valid", 128'(query_seq_block_valid_out), 128'(4'b0010));
    #2 rst = 1'b1;
    #1;
    chk("c_rst_in_rdy", 128'(in_rdy), 128'(1));
    chk("c_rst_info_valid", 128'(query_info_valid_out), 128'(0));
    chk("c_rst_blk_valid", 128'(query_seq_block_valid_out), 128'(0));
    chk("c_rst_sel", 128'(engine_sel_out), 128'(0));
    chk("c_rst_cnt", 128'(queries_dispatched_out), 128'(0));
    chk("c_rst_busy", 128'(busy_out), 128'(0));
    chk("c_rst_header", hdr_now(), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; blk_rdy = '0;
    exp_ptr = 0; exp_cnt = 0;
    drive_query(16'd1, 0, 1000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
